// File: rtl/fog_param_ctrl_if.sv
// rtl/fog_param_ctrl_if.sv - command-side write/commit bus for the FOG parameter controller
interface fog_param_ctrl_if;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [3:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_commit;
  logic        i_load_default;
  logic        i_period_start;
  logic        o_armed;
  logic        o_commit_done;
  logic        o_timeout;
  logic        o_err_addr;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_commit, i_load_default, i_period_start,
    input  o_wr_ready, o_armed, o_commit_done, o_timeout, o_err_addr
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_commit, i_load_default, i_period_start,
    output o_wr_ready, o_armed, o_commit_done, o_timeout, o_err_addr
  );
endinterface

// File: rtl/fog_param_ctrl.sv
// rtl/fog_param_ctrl.sv - shadow/active FOG parameter set with atomic apply on modulation-period boundary
module fog_param_ctrl #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int AVG_MAX     = 15,
  parameter int GAIN_MAX    = 31
) (
  input  logic                  CLOCK_CPU,
  input  logic                  RST_SYNC_N,
  fog_param_ctrl_if.slave       bus,
  output logic [31:0]           var_freq_cnt,
  output logic [31:0]           var_amp_H,
  output logic [31:0]           var_amp_L,
  output logic                  var_polarity,
  output logic [31:0]           var_wait_cnt,
  output logic [31:0]           var_err_offset,
  output logic [31:0]           var_avg_sel,
  output logic [31:0]           var_gainSel_step,
  output logic [31:0]           var_gainSel_ramp,
  output logic [31:0]           var_fb_ON,
  output logic [31:0]           var_const_step
);

  localparam int NREG = 11;
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] DFLT [0:NREG-1] = '{
    32'd1000, 32'd5000, 32'd5000, 32'd0, 32'd50, 32'd0, 32'd10, 32'd5, 32'd10, 32'd1, 32'd100
  };

  typedef enum logic {IDLE, ARMED} state_t;

  state_t        state, state_nxt;
  logic [31:0]   shadow [0:NREG-1];
  logic [31:0]   active [0:NREG-1];
  logic [CW-1:0] cnt;
  logic          wr_fire, addr_ok, cnt_end, apply_go, forced;

  // Field-specific storage rules applied before the value lands in the shadow set
  function automatic logic [31:0] sanitize(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (a)
      4'd3, 4'd9: r = {31'd0, d[0]};
      4'd6:       if (d > 32'(AVG_MAX)) r = 32'(AVG_MAX);
      4'd7, 4'd8: if (d > 32'(GAIN_MAX)) r = 32'(GAIN_MAX);
      default:    r = d;
    endcase
    return r;
  endfunction

  assign wr_fire  = bus.i_wr_valid && bus.o_wr_ready;
  assign addr_ok  = (bus.i_wr_addr <= 4'd10);
  assign cnt_end  = (cnt == CW'(TIMEOUT_CYC - 1));
  assign apply_go = (state == ARMED) && (bus.i_period_start || cnt_end);
  assign forced   = (state == ARMED) && !bus.i_period_start && cnt_end;

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_commit) state_nxt = ARMED;
      ARMED:   if (apply_go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_wr_ready = (state == IDLE);
    bus.o_armed    = (state == ARMED);
  end

  // Default reload wins over a coincident write; a write alongside i_commit still lands
  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= DFLT[i];
    end else if (state == IDLE) begin
      if (bus.i_load_default && !bus.i_commit) begin
        for (int i = 0; i < NREG; i++) shadow[i] <= DFLT[i];
      end else if (wr_fire && addr_ok) begin
        shadow[bus.i_wr_addr] <= sanitize(bus.i_wr_addr, bus.i_wr_data);
      end
    end
  end

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      for (int i = 0; i < NREG; i++) active[i] <= DFLT[i];
    end else if (apply_go) begin
      for (int i = 0; i < NREG; i++) active[i] <= shadow[i];
    end
  end

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      cnt               <= '0;
      bus.o_commit_done <= 1'b0;
      bus.o_timeout     <= 1'b0;
      bus.o_err_addr    <= 1'b0;
    end else begin
      bus.o_commit_done <= apply_go;
      bus.o_err_addr    <= wr_fire && !addr_ok;
      if (apply_go) bus.o_timeout <= forced;
      if (state == ARMED && !apply_go) cnt <= cnt + CW'(1);
      else                             cnt <= '0;
    end
  end

  // Polarity entry only ever holds bit0, so the OR-reduce equals that bit
  assign var_freq_cnt     = active[0];
  assign var_amp_H        = active[1];
  assign var_amp_L        = active[2];
  assign var_polarity     = |active[3];
  assign var_wait_cnt     = active[4];
  assign var_err_offset   = active[5];
  assign var_avg_sel      = active[6];
  assign var_gainSel_step = active[7];
  assign var_gainSel_ramp = active[8];
  assign var_fb_ON        = active[9];
  assign var_const_step   = active[10];

endmodule

// File: tb/tb_fog_param_ctrl.sv
// tb/tb_fog_param_ctrl.sv - scoreboard bench for fog_param_ctrl
module tb_fog_param_ctrl;
  localparam int TMO = 500;
  localparam logic [10:0][31:0] TB_DFLT = {
    32'd100, 32'd1, 32'd10, 32'd5, 32'd10, 32'd0, 32'd50, 32'd0, 32'd5000, 32'd5000, 32'd1000
  };

  typedef struct packed {
    logic              is_err;
    logic              tmo;
    logic [10:0][31:0] vals;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fog_param_ctrl_if bus();
  logic [31:0] v_freq, v_amph, v_ampl, v_wait, v_erro, v_avg, v_gst, v_grm, v_fb, v_cst;
  logic        v_pol;
  logic [10:0][31:0] dut_vals;
  logic [10:0][31:0] model;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n, arm_cnt;

  fog_param_ctrl #(.TIMEOUT_CYC(TMO), .AVG_MAX(15), .GAIN_MAX(31)) dut (
    .CLOCK_CPU(clk), .RST_SYNC_N(rst_n), .bus(bus),
    .var_freq_cnt(v_freq), .var_amp_H(v_amph), .var_amp_L(v_ampl), .var_polarity(v_pol),
    .var_wait_cnt(v_wait), .var_err_offset(v_erro), .var_avg_sel(v_avg),
    .var_gainSel_step(v_gst), .var_gainSel_ramp(v_grm), .var_fb_ON(v_fb), .var_const_step(v_cst)
  );

  assign dut_vals = {v_cst, v_fb, v_grm, v_gst, v_avg, v_erro, v_wait, {31'd0, v_pol}, v_ampl, v_amph, v_freq};

  task automatic chk(input string nm, input logic [351:0] act, input logic [351:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (bus.o_commit_done || bus.o_err_addr)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {bus.o_commit_done, bus.o_err_addr}, 352'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind", {bus.o_commit_done, bus.o_err_addr}, {!e.is_err, e.is_err});
        chk("event_vals", dut_vals, e.vals);
        if (!e.is_err) chk("event_timeout", bus.o_timeout, e.tmo);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
    cycle();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic commit();
    bus.i_commit = 1'b1;
    cycle();
    bus.i_commit = 1'b0;
  endtask

  task automatic pstart();
    bus.i_period_start = 1'b1;
    cycle();
    bus.i_period_start = 1'b0;
  endtask

  task automatic push_done(input logic tmo);
    sb.push_back('{is_err: 1'b0, tmo: tmo, vals: model});
  endtask

  initial begin
    bus.i_wr_valid = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_commit = 1'b0; bus.i_load_default = 1'b0; bus.i_period_start = 1'b0;
    model = TB_DFLT;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("reset_vals", dut_vals, TB_DFLT);
    chk("reset_flags", {bus.o_wr_ready, bus.o_armed, bus.o_commit_done, bus.o_timeout, bus.o_err_addr}, 5'b10000);

    // Writes stay in shadow until a boundary apply
    wr(4'd0, 32'd2000);
    wr(4'd6, 32'd40);
    chk("no_change_on_write", dut_vals, TB_DFLT);
    model[0] = 32'd2000; model[6] = 32'd15;
    push_done(1'b0);
    commit();
    cycle();
    chk("armed_flags", {bus.o_wr_ready, bus.o_armed}, 2'b01);
    pstart();
    chk("done_high", bus.o_commit_done, 1'b1);
    cycle();
    chk("done_one_cycle", {bus.o_commit_done, bus.o_armed, bus.o_wr_ready}, 3'b001);

    // Boundary in the commit cycle is ignored; next one 300 cycles later applies
    wr(4'd1, 32'hFFFF_FFF9);
    model[1] = 32'hFFFF_FFF9;
    push_done(1'b0);
    bus.i_commit = 1'b1; bus.i_period_start = 1'b1;
    cycle();
    bus.i_commit = 1'b0; bus.i_period_start = 1'b0;
    chk("no_apply_same_cycle", dut_vals[1], 32'd5000);
    arm_cnt = 0;
    for (int i = 0; i < 299; i++) begin
      if (bus.o_armed) arm_cnt++;
      cycle();
    end
    if (bus.o_armed) arm_cnt++;
    pstart();
    if (bus.o_armed) arm_cnt++;
    chk("armed_300_cycles", arm_cnt, 300);

    // Forced apply after TIMEOUT_CYC cycles without a boundary
    wr(4'd2, 32'd777);
    model[2] = 32'd777;
    push_done(1'b1);
    commit();
    n = 0;
    while (!bus.o_commit_done && n < TMO + 100) begin
      cycle();
      n++;
    end
    chk("timeout_latency", n, TMO);
    repeat (3) cycle();
    chk("timeout_sticky", bus.o_timeout, 1'b1);

    // Boundary on the timeout cycle counts as a normal apply
    wr(4'd5, 32'hFFFF_FF38);
    model[5] = 32'hFFFF_FF38;
    push_done(1'b0);
    commit();
    repeat (TMO - 1) cycle();
    pstart();
    cycle();
    chk("timeout_cleared", bus.o_timeout, 1'b0);

    // Unmapped address: error pulse, no shadow change
    sb.push_back('{is_err: 1'b1, tmo: 1'b0, vals: model});
    wr(4'd12, 32'd5);
    cycle();
    chk("err_addr_cleared", bus.o_err_addr, 1'b0);

    // Write during ARMED is not accepted
    push_done(1'b0);
    commit();
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 32'd9999;
    chk("ready_low_armed", bus.o_wr_ready, 1'b0);
    cycle();
    bus.i_wr_valid = 1'b0;
    pstart();
    cycle();

    // Default reload wins over a coincident write
    bus.i_load_default = 1'b1; bus.i_wr_valid = 1'b1; bus.i_wr_addr = 4'd4; bus.i_wr_data = 32'd77;
    cycle();
    bus.i_load_default = 1'b0; bus.i_wr_valid = 1'b0;
    model = TB_DFLT;
    push_done(1'b0);
    commit();
    pstart();
    cycle();

    // bit0 fields and gain clamp
    wr(4'd9, 32'hFFFF_FFFE);
    wr(4'd3, 32'd3);
    wr(4'd8, 32'd100);
    model[9] = 32'd0; model[3] = 32'd1; model[8] = 32'd31;
    push_done(1'b0);
    commit();
    pstart();
    cycle();

    // Reset mid-ARMED drops the pending commit and shadow writes
    wr(4'd0, 32'd3000);
    commit();
    repeat (5) cycle();
    rst_n = 1'b0;
    #1;
    chk("reset_armed_vals", dut_vals, TB_DFLT);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_reset_idle", {bus.o_wr_ready, bus.o_armed, bus.o_timeout}, 3'b100);
    pstart();
    repeat (3) cycle();
    model = TB_DFLT;
    push_done(1'b0);
    commit();
    pstart();
    repeat (3) cycle();

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
